ciphertext_unpack: RTL and testbench
====================================

Name: ciphertext_unpack

Overview:
- Decaps-side counterpart of the encapsulation ciphertext packer.
- Takes a packed ciphertext vector c (CIPHERTEXT_BITS wide) and streams the 701 coefficients of c in Rq, one per handshake, to the decapsulation multiplier.
- Coefficients 0..699 are unpacked from 13-bit fields.
- Coefficient 700 is not transmitted. It is reconstructed as the negated sum of the others mod q (sum-zero ideal).

Parameters:
- N, 701, polynomial length (coefficient count).
- LOGQ, 13, coefficient width; q = 2^LOGQ = 8192.
- CIPHERTEXT_BITS, 9104, packed ciphertext width: (N-1)*LOGQ = 9100 data bits plus 4 pad bits.
- IDX_W, 10, width of coefficient index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; loads c_in and begins unpacking.
- c_in  input  CIPHERTEXT_BITS [CIPHERTEXT_BITS:1]  packed ciphertext; sampled only on accepted start.
- coef_ready  input  1  downstream ready.
- coef_valid  output  1  coef_out/coef_idx valid.
- coef_out  output  LOGQ  coefficient value, 0..8191.
- coef_idx  output  IDX_W  coefficient index, 0..700.
- busy  output  1  high from accepted start until final handshake.
- done  output  1  one-cycle pulse after coefficient 700 handshake.

Behaviour:
- Field mapping: coefficient i (0..699) = c_in[LOGQ*i+LOGQ : LOGQ*i+1], LSB side first. Pad bits c_in[9104:9101] are ignored.
- Reset (rst=1 at edge): state IDLE. coef_valid=0, coef_out=0, coef_idx=0, busy=0, done=0. Internal shift register and accumulator are cleared. Reset overrides start in the same cycle. Reset mid-stream aborts with no done pulse.
- States: IDLE, STREAM, LAST, FIN.
- IDLE:
  - start=1 loads the shift register with c_in, clears accumulator, sets idx=0, busy=1, goes to STREAM.
  - coef_valid rises the cycle after start (latency 1).
- STREAM:
  - coef_out = shift_reg[LOGQ:1], coef_valid=1.
  - On coef_valid & coef_ready: acc <= (acc + coef_out) mod 2^LOGQ; shift right by LOGQ; idx++.
  - Handshake at idx=699 moves to LAST.
- LAST:
  - coef_out = (2^LOGQ - acc) mod 2^LOGQ, i.e. two's-complement negate truncated to LOGQ bits. acc=0 gives 0.
  - coef_idx=700, coef_valid=1.
  - Handshake moves to FIN.
- FIN: done=1 for exactly one cycle; coef_valid=0, busy=0; next state IDLE.
- Backpressure: while coef_valid=1 and coef_ready=0, coef_out and coef_idx hold stable. No skipped or duplicated coefficient under any ready pattern.
- Throughput: with coef_ready tied high, one coefficient per cycle. Start-to-done is 703 cycles (start edge, 701 handshakes, done).
- start while busy=1 is ignored; c_in changes during a stream have no effect.
- start in the FIN cycle is ignored. start in the next IDLE cycle is accepted; back-to-back gap ≥1 idle cycle.
- Accumulator is exactly LOGQ bits; wrap-around is intended, mod q arithmetic.
- coef_idx equals the index of the coefficient currently on coef_out.

Test Plan:
- All-zero c_in, ready=1 → 701 coefficients all 0, idx 0..700 in order. done exactly 703 cycles after start. busy falls with done.
- Field i = i (i = 0..699) → coefficient i = i. Coefficient 700 = (-244650) mod 8192 = 1110.
- Every field = 8191 (all data bits 1) → coefficients 0..699 = 8191. Coefficient 700 = 700. Pad bits set to 1 must not alter any output.
- Random c_in with pseudo-random coef_ready (≈50% duty) → outputs stable while stalled. Stream matches golden unpack; last coefficient is zero-sum checked against a model. done occurs once.
- start pulsed at idx=300 with a different c_in → ignored; stream continues from the original data. start one cycle after done → a new stream begins.
- rst asserted at idx=450 → next cycle coef_valid=0, busy=0, coef_idx=0, no done pulse. Fresh start then produces the correct full stream.

Source files
------------

// File: rtl/ciphertext_unpack.sv
// Unpacks a packed ciphertext into 701 Rq coefficients, streamed one per handshake.
// The last coefficient is not transmitted; it is rebuilt as the negated sum of the others mod q.
module ciphertext_unpack #(
  parameter int N               = 701,
  parameter int LOGQ            = 13,
  parameter int CIPHERTEXT_BITS = 9104,
  parameter int IDX_W           = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CIPHERTEXT_BITS:1] c_in,
  input  logic                     coef_ready,
  output logic                     coef_valid,
  output logic [LOGQ-1:0]          coef_out,
  output logic [IDX_W-1:0]         coef_idx,
  output logic                     busy,
  output logic                     done
);

  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_LAST,
    S_FIN
  } state_t;

  state_t                     state_q, state_d;
  logic [CIPHERTEXT_BITS:1]   sr_q, sr_d;
  logic [LOGQ-1:0]            acc_q, acc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    coef_valid = 1'b0;
    coef_out   = '0;
    coef_idx   = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = c_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        coef_valid = 1'b1;
        busy       = 1'b1;
        coef_out   = sr_q[LOGQ:1];
        coef_idx   = idx_q;
        if (coef_ready) begin
          acc_d = acc_q + sr_q[LOGQ:1];
          sr_d  = sr_q >> LOGQ;
          idx_d = idx_q + 1'b1;
          if (idx_q == PRE_LAST_IDX) begin
            state_d = S_LAST;
          end
        end
      end

      // idx_q already sits at N-1 here; the coefficient is the mod-q negation of the running sum
      S_LAST: begin
        coef_valid = 1'b1;
        busy       = 1'b1;
        coef_out   = '0 - acc_q;
        coef_idx   = idx_q;
        if (coef_ready) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ciphertext_unpack.sv
// Scoreboard bench for ciphertext_unpack: stimulus pushes expected coefficients, a monitor pops on handshakes.
module tb_ciphertext_unpack;

  logic          clk;
  logic          rst;
  logic          start;
  logic [9104:1] c_in;
  logic          coef_ready;
  logic          coef_valid;
  logic [12:0]   coef_out;
  logic [9:0]    coef_idx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  logic [22:0] exp_q[$];

  ciphertext_unpack #(
    .N(701),
    .LOGQ(13),
    .CIPHERTEXT_BITS(9104),
    .IDX_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .c_in(c_in),
    .coef_ready(coef_ready),
    .coef_valid(coef_valid),
    .coef_out(coef_out),
    .coef_idx(coef_idx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog timeout");
  end

  // Ready driver: tied high, or pseudo-random ~50% duty
  initial begin
    coef_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      coef_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  // Monitor: pop one expectation per handshake, and check hold-stability under stalls
  initial begin
    logic        stalled;
    logic [12:0] held_out;
    logic [9:0]  held_idx;
    logic [22:0] e;
    stalled = 1'b0;
    held_out = '0;
    held_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst && coef_valid) begin
        if (stalled) begin
          checks++;
          if (coef_out !== held_out || coef_idx !== held_idx) begin
            errors++;
            $display("FAIL stall_hold: got out=%0d idx=%0d, required out=%0d idx=%0d",
                     coef_out, coef_idx, held_out, held_idx);
          end
        end
        if (coef_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_coef: got out=%0d idx=%0d, required no output", coef_out, coef_idx);
          end else begin
            e = exp_q.pop_front();
            if (coef_idx !== e[22:13] || coef_out !== e[12:0]) begin
              errors++;
              $display("FAIL coef: got idx=%0d out=%0d, required idx=%0d out=%0d",
                       coef_idx, coef_out, e[22:13], e[12:0]);
            end
          end
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          held_out = coef_out;
          held_idx = coef_idx;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int idx, input int val);
    exp_q.push_back({10'(idx), 13'(val)});
  endtask

  // Golden unpack: fields LSB-first, last coefficient = -(sum) mod 8192; stops below idx limit
  task automatic push_model(input logic [9104:1] c, input int limit);
    logic [12:0] sum;
    logic [12:0] f;
    sum = '0;
    for (int i = 0; i < 700; i++) begin
      f = c[13*i+1 +: 13];
      sum = sum + f;
      if (i < limit) push_exp(i, int'(f));
    end
    if (limit > 700) push_exp(700, int'(13'd0 - sum));
  endtask

  task automatic rand_vec(output logic [9104:1] c);
    for (int i = 1; i <= 9104; i++) c[i] = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1; returns at posedge+1 of the first streaming cycle
  task automatic start_stream(input string name, input logic [9104:1] c);
    start = 1'b1;
    c_in  = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    c_in  = ~c;
    chk({name, "_valid_latency"}, int'(coef_valid), 1);
    chk({name, "_busy_after_start"}, int'(busy), 1);
  endtask

  task automatic wait_idx(input int target);
    int n;
    n = 0;
    while (!(coef_valid && coef_idx == 10'(target)) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idx_reached", int'(coef_valid && coef_idx == 10'(target)), 1);
  endtask

  // Returns at the negedge of the done cycle
  task automatic finish_stream(input string name, input int done_before);
    int edges;
    edges = 0;
    while (!done && edges < 5000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({name, "_done_seen"}, int'(done), 1);
    // start cycle + 701 handshake cycles + done cycle
    if (ready_mode == 0) chk({name, "_start_to_done_cycles"}, edges + 2, 703);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    chk({name, "_valid_at_done"}, int'(coef_valid), 0);
    @(negedge clk);
    chk({name, "_done_count"}, done_cnt - done_before, 1);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [9104:1] c;
    logic [9104:1] c2;
    int d0;

    rst   = 1'b1;
    start = 1'b0;
    c_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(coef_valid), 0);
    chk("reset_out", int'(coef_out), 0);
    chk("reset_idx", int'(coef_idx), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    // reset wins over a simultaneous start
    start = 1'b1;
    c_in  = '1;
    @(posedge clk);
    #1;
    chk("rst_over_start_valid", int'(coef_valid), 0);
    chk("rst_over_start_busy", int'(busy), 0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;

    // All-zero ciphertext
    ready_mode = 0;
    for (int i = 0; i <= 700; i++) push_exp(i, 0);
    d0 = done_cnt;
    start_stream("zero", '0);
    finish_stream("zero", d0);
    @(posedge clk);
    #1;
    chk("done_single_cycle", int'(done), 0);

    // Field i = i, pad bits set
    c = '0;
    for (int i = 0; i < 700; i++) c[13*i+1 +: 13] = 13'(i);
    c[9104:9101] = 4'b1010;
    for (int i = 0; i < 700; i++) push_exp(i, i);
    push_exp(700, 1110);
    d0 = done_cnt;
    start_stream("ramp", c);
    finish_stream("ramp", d0);
    @(posedge clk);
    #1;

    // All ones including pad
    c = '1;
    for (int i = 0; i < 700; i++) push_exp(i, 8191);
    push_exp(700, 700);
    d0 = done_cnt;
    start_stream("ones", c);
    finish_stream("ones", d0);
    @(posedge clk);
    #1;

    // Random data, random ready, start ignored mid-stream
    ready_mode = 1;
    rand_vec(c);
    push_model(c, 701);
    d0 = done_cnt;
    start_stream("rand1", c);
    wait_idx(300);
    rand_vec(c2);
    start = 1'b1;
    c_in  = c2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_ignored_busy", int'(busy), 1);
    finish_stream("rand1", d0);

    // start raised in FIN is ignored, held into the next IDLE cycle it is accepted
    rand_vec(c2);
    push_model(c2, 701);
    start = 1'b1;
    c_in  = c2;
    @(posedge clk);
    #1;
    chk("start_in_fin_ignored", int'(coef_valid), 0);
    d0 = done_cnt;
    start_stream("b2b", c2);
    finish_stream("b2b", d0);
    @(posedge clk);
    #1;

    // Reset at idx 450 aborts without done
    ready_mode = 0;
    @(posedge clk);
    #1;
    rand_vec(c);
    push_model(c, 450);
    d0 = done_cnt;
    start_stream("abort", c);
    wait_idx(450);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", int'(coef_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_idx", int'(coef_idx), 0);
    chk("abort_queue_drained", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    // Fresh stream after abort
    rand_vec(c);
    push_model(c, 701);
    d0 = done_cnt;
    start_stream("fresh", c);
    finish_stream("fresh", d0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
